// File: rtl/my_riscv_core_input_stage.sv
// Master-side input stage of the L1 AHB bus matrix. It holds a stalled address
// phase, drives the output-stage request line and relays the slave data-phase ready/response.
module my_riscv_core_input_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  // master side
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  // toward the output stages
  output logic                  HSELI,
  output logic [ADDR_WIDTH-1:0] HADDRI,
  output logic [1:0]            HTRANSI,
  output logic                  HWRITEI,
  output logic [2:0]            HSIZEI,
  output logic [2:0]            HBURSTI,
  output logic [3:0]            HPROTI,
  output logic                  HMASTLOCKI,
  output logic                  trans_req,
  input  logic                  addr_ack,
  input  logic                  data_ready,
  input  logic                  data_resp
);

  // Encoding is {pend, data_phase}; 2'b11 is deliberately left out.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_PEND = 2'b10
  } state_e;

  typedef struct packed {
    logic                  sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic                  lock;
  } addr_phase_t;

  state_e      state_q, state_d;
  addr_phase_t hold_q, hold_d;
  addr_phase_t live;
  addr_phase_t sel_ap;

  logic pend;
  logic data_phase;
  logic new_tr;
  logic accept;
  logic capture;

  assign pend       = (state_q == ST_PEND);
  assign data_phase = (state_q == ST_DATA);

  // Only NONSEQ/SEQ on a completed bus cycle count as a real transfer.
  assign new_tr  = HSELS & HREADYS & HTRANSS[1];
  assign accept  = addr_ack & (pend | new_tr);
  assign capture = ~pend & new_tr & ~addr_ack;

  assign live = '{
    sel:   HSELS & HREADYS,
    addr:  HADDRS,
    trans: HTRANSS,
    write: HWRITES,
    size:  HSIZES,
    burst: HBURSTS,
    prot:  HPROTS,
    lock:  HMASTLOCKS
  };

  assign sel_ap     = pend ? hold_q : live;
  assign HSELI      = sel_ap.sel;
  assign HADDRI     = sel_ap.addr;
  assign HTRANSI    = sel_ap.trans;
  assign HWRITEI    = sel_ap.write;
  assign HSIZEI     = sel_ap.size;
  assign HBURSTI    = sel_ap.burst;
  assign HPROTI     = sel_ap.prot;
  assign HMASTLOCKI = sel_ap.lock;

  assign trans_req  = pend | new_tr;
  assign HREADYOUTS = pend ? 1'b0 : (data_phase ? data_ready : 1'b1);
  assign HRESPS     = data_phase & data_resp;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (capture) begin
      hold_d = live;
    end
    case (state_q)
      ST_IDLE, ST_DATA: begin
        // A new accept keeps the data phase alive even if the old one completes now.
        if (accept) begin
          state_d = ST_DATA;
        end else if (capture) begin
          state_d = ST_PEND;
        end else if (data_phase && data_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (addr_ack) begin
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the holding register is reset so a dropped transfer can never reappear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assert property (@(posedge HCLK) disable iff (!HRESETn) state_q != state_e'(2'b11))
    else $error("input stage reached illegal pend+data_phase state");

endmodule
